// File: rtl/s2p_word_deserializer.sv
// s2p_word_deserializer
// Serial-to-parallel word deserializer for the USB/SD bulk data path.
// Accepted serial bits are framed into NUM_BITS-wide words. The bit order is
// chosen per word, and completed words are buffered in a small FIFO with a
// valid/ready handshake and a sticky overflow flag.
// Optional feature macro: S2P_BIT_UNSTUFF_EN adds bit-unstuffing (after six
// accepted ones the next qualified bit is dropped) and drives the stuff_err
// pulse. Without it, every qualified bit is accepted and stuff_err is 0.
// Reset is synchronous and active-low (n_rst). clear flushes the partial word,
// the FIFO and overflow, but keeps the latched bit order.

module s2p_word_deserializer #(
  parameter int NUM_BITS   = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              shift_enable,
  input  logic                              pause,
  input  logic                              serial_in,
  input  logic                              msb_first,
  input  logic                              clear,
  input  logic                              word_ready,
  output logic [NUM_BITS-1:0]               word_out,
  output logic                              word_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic [$clog2(NUM_BITS)-1:0]       bit_count,
  output logic                              overflow,
  output logic                              stuff_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(NUM_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [BW-1:0] LAST_BIT   = BW'(NUM_BITS - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  // Shift-register side state
  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [BW-1:0]       bit_count_q, bit_count_d;
  logic                order_q, order_d;

  // FIFO state
  logic [NUM_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [NUM_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;

  // Handshake and control strobes
  logic strobe;
  logic accept;
  logic cur_order;
  logic word_done;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_push;
  logic fifo_drop;

`ifdef S2P_BIT_UNSTUFF_EN
  logic [2:0] ones_run_q, ones_run_d;
  logic       stuff_err_q, stuff_err_d;
  logic       stuff_drop;
`endif

  // Qualify the bit strobe; with unstuffing, the bit after six ones is dropped
  always_comb begin
    strobe = shift_enable & ~pause;
`ifdef S2P_BIT_UNSTUFF_EN
    stuff_drop = strobe & (ones_run_q == 3'd6);
    accept     = strobe & ~stuff_drop;
`else
    accept     = strobe;
`endif
  end

`ifdef S2P_BIT_UNSTUFF_EN
  // Track the run of accepted ones and flag a 1 found in the stuff slot
  always_comb begin
    ones_run_d  = ones_run_q;
    stuff_err_d = 1'b0;
    if (stuff_drop) begin
      ones_run_d  = 3'd0;
      stuff_err_d = serial_in;
    end else if (accept) begin
      ones_run_d = serial_in ? (ones_run_q + 3'd1) : 3'd0;
    end
    if (clear) begin
      ones_run_d  = 3'd0;
      stuff_err_d = 1'b0;
    end
  end
`endif

  // Shift accepted bits in; the order is sampled on the first bit of each word
  always_comb begin
    sr_d        = sr_q;
    bit_count_d = bit_count_q;
    order_d     = order_q;
    word_done   = 1'b0;
    cur_order   = (bit_count_q == '0) ? msb_first : order_q;
    if (accept) begin
      if (bit_count_q == '0) begin
        order_d = msb_first;
      end
      if (cur_order) begin
        sr_d = {sr_q[NUM_BITS-2:0], serial_in};
      end else begin
        sr_d = {serial_in, sr_q[NUM_BITS-1:1]};
      end
      if (bit_count_q == LAST_BIT) begin
        bit_count_d = '0;
        word_done   = 1'b1;
      end else begin
        bit_count_d = bit_count_q + BW'(1);
      end
    end
    if (clear) begin
      sr_d        = '1;
      bit_count_d = '0;
      word_done   = 1'b0;
    end
  end

  // FIFO bookkeeping: a push into a full FIFO succeeds only alongside a pop
  always_comb begin
    fifo_pop   = (count_q != '0) & word_ready;
    fifo_full  = (count_q == FULL_COUNT);
    fifo_push  = word_done & (~fifo_full | fifo_pop);
    fifo_drop  = word_done & fifo_full & ~fifo_pop;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | fifo_drop;
    if (fifo_push) begin
      mem_d[wr_ptr_q] = sr_d;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sr_q        <= '1;
      bit_count_q <= '0;
      order_q     <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bit_count_q <= bit_count_d;
      order_q     <= order_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Word storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef S2P_BIT_UNSTUFF_EN
  // Unstuffing state register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ones_run_q  <= 3'd0;
      stuff_err_q <= 1'b0;
    end else begin
      ones_run_q  <= ones_run_d;
      stuff_err_q <= stuff_err_d;
    end
  end
`endif

  // Output drive; the head reads as all ones whenever the FIFO is empty
  always_comb begin
    word_valid = (count_q != '0);
    word_out   = word_valid ? mem_q[rd_ptr_q] : '1;
    fifo_count = count_q;
    bit_count  = bit_count_q;
    overflow   = overflow_q;
`ifdef S2P_BIT_UNSTUFF_EN
    stuff_err  = stuff_err_q;
`else
    stuff_err  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_s2p_word_deserializer.sv
// tb_s2p_word_deserializer
// Self-checking bench for s2p_word_deserializer (NUM_BITS=8, FIFO_DEPTH=2).
// A word-level reference model (bit list, word queue) predicts every output
// each cycle; table vectors and hand-written sequences add fixed expectations.
// Unstuffing sequences run only when S2P_BIT_UNSTUFF_EN is defined.
`timescale 1ns/1ps

module tb_s2p_word_deserializer;

  localparam int NB = 8;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          shift_enable;
  logic          pause;
  logic          serial_in;
  logic          msb_first;
  logic          clear;
  logic          word_ready;
  logic [NB-1:0] word_out;
  logic          word_valid;
  logic [1:0]    fifo_count;
  logic [2:0]    bit_count;
  logic          overflow;
  logic          stuff_err;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic          m_bits [$];
  logic          m_order;
  logic [NB-1:0] m_fifo [$];
  logic          m_overflow;
  int            m_ones;
  logic          m_stuff_err;

  typedef struct {
    logic [7:0] stream;
    logic       msb;
    int         toggle_from;
    logic [7:0] exp_word;
  } vec_t;

  vec_t vecs [8];

  s2p_word_deserializer #(.NUM_BITS(NB), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_enable),
    .pause        (pause),
    .serial_in    (serial_in),
    .msb_first    (msb_first),
    .clear        (clear),
    .word_ready   (word_ready),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .fifo_count   (fifo_count),
    .bit_count    (bit_count),
    .overflow     (overflow),
    .stuff_err    (stuff_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single comparison with FAIL reporting
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Predict the post-edge state from the rules of the block
  task automatic modelStep(input logic rst_v, input logic se, input logic ps, input logic sin,
                           input logic msb, input logic clr, input logic rdy);
    logic          acc;
    logic          pop;
    logic [NB-1:0] w;
    if (!rst_v || clr) begin
      m_bits.delete();
      m_fifo.delete();
      m_overflow  = 1'b0;
      m_ones      = 0;
      m_stuff_err = 1'b0;
      if (!rst_v) m_order = 1'b1;
      return;
    end
    pop = (m_fifo.size() > 0) && rdy;
    acc = se & ~ps;
    m_stuff_err = 1'b0;
`ifdef S2P_BIT_UNSTUFF_EN
    if (acc && m_ones == 6) begin
      acc = 1'b0;
      m_ones = 0;
      m_stuff_err = sin;
    end else if (acc) begin
      m_ones = sin ? m_ones + 1 : 0;
    end
`endif
    if (pop) void'(m_fifo.pop_front());
    if (acc) begin
      if (m_bits.size() == 0) m_order = msb;
      m_bits.push_back(sin);
      if (m_bits.size() == NB) begin
        w = '0;
        for (int i = 0; i < NB; i++) begin
          if (m_order) w = (w << 1) | NB'(m_bits[i]);
          else if (m_bits[i]) w = w | (NB'(1) << i);
        end
        m_bits.delete();
        if (m_fifo.size() < FD) m_fifo.push_back(w);
        else m_overflow = 1'b1;
      end
    end
  endtask

  // Compare every DUT output with the model
  task automatic checkOutput();
    checkVal("word_valid", 32'(word_valid), 32'(m_fifo.size() > 0));
    checkVal("word_out", 32'(word_out), (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'hFF);
    checkVal("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
    checkVal("bit_count", 32'(bit_count), 32'(m_bits.size()));
    checkVal("overflow", 32'(overflow), 32'(m_overflow));
    checkVal("stuff_err", 32'(stuff_err), 32'(m_stuff_err));
  endtask

  // Drive one cycle of inputs, advance the model and check after the edge
  task automatic applyStimulus(input logic rst_v, input logic se, input logic ps, input logic sin,
                               input logic msb, input logic clr, input logic rdy);
    n_rst = rst_v; shift_enable = se; pause = ps; serial_in = sin;
    msb_first = msb; clear = clr; word_ready = rdy;
    modelStep(rst_v, se, ps, sin, msb, clr, rdy);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  // Shift a word in, stream order taken from bit 7 down to bit 0
  task automatic sendWord(input logic [7:0] stream, input logic msb, input logic rdy);
    for (int i = 7; i >= 0; i--) applyStimulus(1, 1, 0, stream[i], msb, 0, rdy);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1, 0, 0, 0, 1, 0, rdy);
  endtask

  task automatic doClear();
    applyStimulus(1, 1, 0, 1, 1, 1, 0);
  endtask

  // Main test sequence
  initial begin
    logic m;
    vecs[0] = '{8'hD2, 1'b1, -1, 8'hD2};
    vecs[1] = '{8'hD2, 1'b0, -1, 8'h4B};
    vecs[2] = '{8'hD2, 1'b1,  3, 8'hD2};
    vecs[3] = '{8'hD2, 1'b0,  3, 8'h4B};
    vecs[4] = '{8'h01, 1'b1, -1, 8'h01};
    vecs[5] = '{8'h01, 1'b0, -1, 8'h80};
    vecs[6] = '{8'hF0, 1'b0, -1, 8'h0F};
    vecs[7] = '{8'h3C, 1'b1, -1, 8'h3C};
    m_order = 1'b1;
    m_overflow = 1'b0;
    m_ones = 0;
    m_stuff_err = 1'b0;

    // Reset held two cycles with the strobe active
    applyStimulus(0, 1, 0, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 1, 1, 0, 0);
    checkVal("rst_word_valid", 32'(word_valid), 0);
    checkVal("rst_word_out", 32'(word_out), 32'hFF);
    checkVal("rst_fifo_count", 32'(fifo_count), 0);
    checkVal("rst_bit_count", 32'(bit_count), 0);
    checkVal("rst_overflow", 32'(overflow), 0);

    // Table vectors: bit order, latching at word start
    for (int v = 0; v < 8; v++) begin
      doClear();
      for (int i = 0; i < 8; i++) begin
        m = vecs[v].msb;
        if (vecs[v].toggle_from >= 0 && i >= vecs[v].toggle_from) m = ~m;
        applyStimulus(1, 1, 0, vecs[v].stream[7-i], m, 0, 0);
      end
      checkVal($sformatf("vec%0d_word_out", v), 32'(word_out), 32'(vecs[v].exp_word));
      checkVal($sformatf("vec%0d_valid", v), 32'(word_valid), 1);
      checkVal($sformatf("vec%0d_count", v), 32'(fifo_count), 1);
    end

    // Pause holds the partial word
    doClear();
    for (int i = 7; i >= 4; i--) applyStimulus(1, 1, 0, vecs[0].stream[i], 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 1, 1, 1, 0, 0);
      checkVal("pause_bit_count", 32'(bit_count), 4);
    end
    for (int i = 3; i >= 0; i--) applyStimulus(1, 1, 0, vecs[0].stream[i], 1, 0, 0);
    checkVal("pause_word_out", 32'(word_out), 32'hD2);

    // Overflow: third word dropped, order preserved, flag sticky
    doClear();
    sendWord(8'h11, 1, 0);
    sendWord(8'h22, 1, 0);
    sendWord(8'h33, 1, 0);
    checkVal("ovf_count", 32'(fifo_count), 2);
    checkVal("ovf_flag", 32'(overflow), 1);
    checkVal("ovf_head", 32'(word_out), 32'h11);
    idle(1);
    checkVal("ovf_pop1", 32'(word_out), 32'h22);
    idle(1);
    checkVal("ovf_empty", 32'(word_valid), 0);
    checkVal("ovf_sticky", 32'(overflow), 1);
    doClear();
    checkVal("ovf_cleared", 32'(overflow), 0);

    // Push into full FIFO with simultaneous pop
    sendWord(8'hAA, 1, 0);
    sendWord(8'hBB, 1, 0);
    for (int i = 7; i >= 1; i--) applyStimulus(1, 1, 0, 8'hCC >> i, 1, 0, 0);
    applyStimulus(1, 1, 0, 1'b0, 1, 0, 1);
    checkVal("fullpop_count", 32'(fifo_count), 2);
    checkVal("fullpop_head", 32'(word_out), 32'hBB);
    checkVal("fullpop_ovf", 32'(overflow), 0);
    idle(1);
    checkVal("fullpop_next", 32'(word_out), 32'hCC);
    idle(1);
    checkVal("fullpop_empty", 32'(word_valid), 0);

    // Clear mid-word with data and overflow pending
    sendWord(8'h5A, 1, 0);
    sendWord(8'h6B, 1, 0);
    sendWord(8'h7C, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, i[0], 1, 0, 0);
    checkVal("clr_pre_bits", 32'(bit_count), 5);
    doClear();
    checkVal("clr_bits", 32'(bit_count), 0);
    checkVal("clr_count", 32'(fifo_count), 0);
    checkVal("clr_ovf", 32'(overflow), 0);

    // Push into empty FIFO with ready high still registers first
    sendWord(8'h96, 1, 1);
    checkVal("bypass_valid", 32'(word_valid), 1);
    checkVal("bypass_word", 32'(word_out), 32'h96);
    idle(1);
    checkVal("bypass_popped", 32'(word_valid), 0);

`ifdef S2P_BIT_UNSTUFF_EN
    // Stuffed zero dropped
    doClear();
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 0, 0);
    checkVal("stuff0_err", 32'(stuff_err), 0);
    checkVal("stuff0_bits", 32'(bit_count), 6);
    applyStimulus(1, 1, 0, 1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 0, 0);
    checkVal("stuff0_word", 32'(word_out), 32'hFE);
    // A 1 in the stuff slot pulses stuff_err and is not counted
    doClear();
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 1, 1, 0, 0);
    applyStimulus(1, 1, 0, 1, 1, 0, 0);
    checkVal("stuff1_err", 32'(stuff_err), 1);
    checkVal("stuff1_bits", 32'(bit_count), 6);
    applyStimulus(1, 1, 0, 1, 1, 0, 0);
    checkVal("stuff1_pulse", 32'(stuff_err), 0);
    applyStimulus(1, 1, 0, 0, 1, 0, 0);
    checkVal("stuff1_word", 32'(word_out), 32'hFE);
`endif

    // Randomized traffic against the model
    doClear();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom % 251) != 0,
                    ($urandom % 4) != 0,
                    ($urandom % 5) == 0,
                    1'($urandom),
                    ($urandom % 3) != 0,
                    ($urandom % 97) == 0,
                    ($urandom % 3) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
